// File: rtl/mem_arb_pkg.sv
// Shared types and RAM geometry for the single-port RAM arbiter.
// The RAM model and the arbiter both take their default widths from here.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Requester A/B command and response signals plus the RAM pin bundle.
// slave = arbiter side, master = requesters and RAM side.
interface sp_ram_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic              a_we, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_rsp_valid, b_rsp_valid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  a_valid, b_valid, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_q,
        output a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_rdata, b_rdata,
               mem_addr, mem_wdata, mem_we
    );

    modport master (
        output a_valid, b_valid, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_q,
        input  a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_rdata, b_rdata,
               mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/sp_ram_arbiter.sv
// Bounded-burst round-robin arbiter sharing one single-port RAM between A and B.
// Grants are combinational (zero latency); read responses follow one cycle later.
module sp_ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sp_ram_arbiter_if.slave   bus
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    arb_state_e        r_state, w_state_nxt;
    owner_e            r_last_owner, w_last_nxt;
    logic [3:0]        r_burst_cnt, w_cnt_nxt, w_cnt_inc;
    logic              r_pend;
    owner_e            r_pend_owner;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;

    logic              w_gnt_a, w_gnt_b, w_gnt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;

    assign w_cnt_inc = (r_burst_cnt < BURST_LIM) ? r_burst_cnt + 4'd1 : r_burst_cnt;

    always_comb begin
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_burst_cnt;
        w_last_nxt  = r_last_owner;
        case (r_state)
            IDLE: begin
                // On a tie the side that did not own the RAM last goes first.
                if (bus.a_valid && (!bus.b_valid || r_last_owner == OWNER_B)) begin
                    w_gnt_a     = 1'b1;
                    w_state_nxt = OWN_A;
                    w_cnt_nxt   = 4'd1;
                end else if (bus.b_valid) begin
                    w_gnt_b     = 1'b1;
                    w_state_nxt = OWN_B;
                    w_cnt_nxt   = 4'd1;
                end
            end
            OWN_A: begin
                if (bus.a_valid && (r_burst_cnt < BURST_LIM || !bus.b_valid)) begin
                    w_gnt_a   = 1'b1;
                    w_cnt_nxt = w_cnt_inc;
                end else if (bus.b_valid) begin
                    w_gnt_b     = 1'b1;
                    w_state_nxt = OWN_B;
                    w_cnt_nxt   = 4'd1;
                end else begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = OWNER_A;
                end
            end
            OWN_B: begin
                if (bus.b_valid && (r_burst_cnt < BURST_LIM || !bus.a_valid)) begin
                    w_gnt_b   = 1'b1;
                    w_cnt_nxt = w_cnt_inc;
                end else if (bus.a_valid) begin
                    w_gnt_a     = 1'b1;
                    w_state_nxt = OWN_A;
                    w_cnt_nxt   = 4'd1;
                end else begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = OWNER_B;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Nothing may be accepted while reset is asserted.
        if (!rst_n) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end
    end

    assign w_gnt = w_gnt_a | w_gnt_b;

    always_comb begin
        w_mem_addr  = r_addr_hold;
        w_mem_wdata = r_wdata_hold;
        w_mem_we    = 1'b0;
        if (w_gnt_a) begin
            w_mem_addr  = bus.a_addr;
            w_mem_wdata = bus.a_wdata;
            w_mem_we    = bus.a_we;
        end else if (w_gnt_b) begin
            w_mem_addr  = bus.b_addr;
            w_mem_wdata = bus.b_wdata;
            w_mem_we    = bus.b_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_owner <= OWNER_B;
            r_burst_cnt  <= 4'd0;
            r_pend       <= 1'b0;
            r_pend_owner <= OWNER_A;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_nxt;
            r_burst_cnt  <= w_cnt_nxt;
            r_pend       <= w_gnt & ~w_mem_we;
            r_pend_owner <= w_gnt_b ? OWNER_B : OWNER_A;
            if (w_gnt) begin
                r_addr_hold  <= w_mem_addr;
                r_wdata_hold <= w_mem_wdata;
            end
        end
    end

    assign bus.a_ready     = w_gnt_a;
    assign bus.b_ready     = w_gnt_b;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.mem_we      = w_mem_we;
    // Gating with rst_n drops a response whose cycle coincides with reset.
    assign bus.a_rsp_valid = rst_n & r_pend & (r_pend_owner == OWNER_A);
    assign bus.b_rsp_valid = rst_n & r_pend & (r_pend_owner == OWNER_B);
    assign bus.a_rdata     = bus.mem_q;
    assign bus.b_rdata     = bus.mem_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench: BURST_MAX=4 arbiter on a behavioural RAM, plus a BURST_MAX=2
// copy fed the same requests for the round-robin pattern.
module tb_sp_ram_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    sp_ram_arbiter_if bus ();
    sp_ram_arbiter_if bus2 ();

    sp_ram_arbiter #(.BURST_MAX(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    sp_ram_arbiter #(.BURST_MAX(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    assign bus2.a_valid = bus.a_valid;
    assign bus2.b_valid = bus.b_valid;
    assign bus2.a_we    = bus.a_we;
    assign bus2.b_we    = bus.b_we;
    assign bus2.a_addr  = bus.a_addr;
    assign bus2.b_addr  = bus.b_addr;
    assign bus2.a_wdata = bus.a_wdata;
    assign bus2.b_wdata = bus.b_wdata;
    assign bus2.mem_q   = '0;

    // 64x8 RAM: write on the edge, registered read.
    logic [7:0] ram [0:63];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_q <= ram[bus.mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic we, input logic [5:0] ad, input logic [7:0] d);
        bus.a_valid = v; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = d;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [5:0] ad, input logic [7:0] d);
        bus.b_valid = v; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = d;
    endtask

    task automatic idle_in();
        set_a(1'b0, 1'b0, 6'h00, 8'h00);
        set_b(1'b0, 1'b0, 6'h00, 8'h00);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);

        // Reset state, with A requesting to show nothing is granted.
        set_a(1'b1, 1'b1, 6'h07, 8'h99);
        #1;
        chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_a_rsp", 32'(bus.a_rsp_valid), 32'd0);
        chk("rst_b_rsp", 32'(bus.b_rsp_valid), 32'd0);

        // A write 0xA5 @0x01, then A read 0x01.
        @(negedge clk);
        rst_n = 1'b1;
        idle_in();
        set_a(1'b1, 1'b1, 6'h01, 8'hA5);
        #1;
        chk("t1_wr_ready", 32'(bus.a_ready), 32'd1);
        chk("t1_wr_b_ready", 32'(bus.b_ready), 32'd0);
        chk("t1_wr_we", 32'(bus.mem_we), 32'd1);
        chk("t1_wr_addr", 32'(bus.mem_addr), 32'h01);
        chk("t1_wr_data", 32'(bus.mem_wdata), 32'hA5);
        @(negedge clk);
        set_a(1'b1, 1'b0, 6'h01, 8'h00);
        #1;
        chk("t1_rd_ready", 32'(bus.a_ready), 32'd1);
        chk("t1_rd_we", 32'(bus.mem_we), 32'd0);
        chk("t1_wr_no_rsp", 32'(bus.a_rsp_valid), 32'd0);
        @(negedge clk);
        idle_in();
        #1;
        chk("t1_rsp_valid", 32'(bus.a_rsp_valid), 32'd1);
        chk("t1_rdata", 32'(bus.a_rdata), 32'hA5);
        chk("t1_b_rsp", 32'(bus.b_rsp_valid), 32'd0);
        chk("t1_b_ready", 32'(bus.b_ready), 32'd0);
        chk("t1_idle_we", 32'(bus.mem_we), 32'd0);
        chk("t1_hold_addr", 32'(bus.mem_addr), 32'h01);
        @(negedge clk);
        #1;
        chk("t1_rsp_one_cyc", 32'(bus.a_rsp_valid), 32'd0);

        // B writes 0xC3 @0x03, A reads 0x03 next cycle.
        set_b(1'b1, 1'b1, 6'h03, 8'hC3);
        #1;
        chk("t4_b_ready", 32'(bus.b_ready), 32'd1);
        chk("t4_b_we", 32'(bus.mem_we), 32'd1);
        chk("t4_b_addr", 32'(bus.mem_addr), 32'h03);
        @(negedge clk);
        idle_in();
        set_a(1'b1, 1'b0, 6'h03, 8'h00);
        #1;
        chk("t4_a_ready", 32'(bus.a_ready), 32'd1);
        chk("t4_b_rsp0", 32'(bus.b_rsp_valid), 32'd0);
        @(negedge clk);
        idle_in();
        #1;
        chk("t4_a_rsp", 32'(bus.a_rsp_valid), 32'd1);
        chk("t4_a_rdata", 32'(bus.a_rdata), 32'hC3);
        chk("t4_b_rsp1", 32'(bus.b_rsp_valid), 32'd0);

        // Both valid from reset for 20 cycles: A writes, B reads.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_a(1'b1, 1'b1, 6'h10, 8'h5A);
        set_b(1'b1, 1'b0, 6'h03, 8'h00);
        for (int i = 0; i < 20; i++) begin
            logic e4a, e2a, p4b;
            e4a = ((i / 4) % 2) == 0;
            e2a = ((i / 2) % 2) == 0;
            p4b = (i > 0) && (((i - 1) / 4) % 2 == 1);
            #1;
            chk($sformatf("rr4_a_ready[%0d]", i), 32'(bus.a_ready), 32'(e4a));
            chk($sformatf("rr4_b_ready[%0d]", i), 32'(bus.b_ready), 32'(!e4a));
            chk($sformatf("rr4_b_rsp[%0d]", i), 32'(bus.b_rsp_valid), 32'(p4b));
            chk($sformatf("rr4_a_rsp[%0d]", i), 32'(bus.a_rsp_valid), 32'd0);
            if (p4b) chk($sformatf("rr4_b_rdata[%0d]", i), 32'(bus.b_rdata), 32'hC3);
            chk($sformatf("rr2_a_ready[%0d]", i), 32'(bus2.a_ready), 32'(e2a));
            chk($sformatf("rr2_one_ready[%0d]", i), 32'(bus2.a_ready) + 32'(bus2.b_ready), 32'd1);
            chk($sformatf("rr2_we[%0d]", i), 32'(bus2.mem_we), 32'(e2a));
            chk($sformatf("rr2_addr[%0d]", i), 32'(bus2.mem_addr), e2a ? 32'h10 : 32'h03);
            @(negedge clk);
        end

        // A read accepted, reset asserted the next cycle drops the response.
        idle_in();
        @(negedge clk);
        set_a(1'b1, 1'b0, 6'h03, 8'h00);
        #1;
        chk("t5_a_ready", 32'(bus.a_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        idle_in();
        #1;
        chk("t5_rsp_dropped", 32'(bus.a_rsp_valid), 32'd0);
        chk("t5_ready", 32'(bus.a_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("t5_rsp_still0", 32'(bus.a_rsp_valid), 32'd0);
        chk("t5_b_rsp", 32'(bus.b_rsp_valid), 32'd0);
        chk("t5_mem_we", 32'(bus.mem_we), 32'd0);
        chk("t5_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("t5_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_a(1'b1, 1'b0, 6'h03, 8'h00);
        set_b(1'b1, 1'b0, 6'h00, 8'h00);
        #1;
        chk("t5_tie_a", 32'(bus.a_ready), 32'd1);
        chk("t5_tie_b", 32'(bus.b_ready), 32'd0);

        // B alone: preload 0x00..0x05 with 0x10..0x15, then read them back.
        @(negedge clk);
        idle_in();
        for (int k = 0; k < 6; k++) begin
            set_b(1'b1, 1'b1, 6'(k), 8'(8'h10 + k));
            #1;
            chk($sformatf("t6_wr_ready[%0d]", k), 32'(bus.b_ready), 32'd1);
            chk($sformatf("t6_wr_we[%0d]", k), 32'(bus.mem_we), 32'd1);
            if (k == 0) begin
                chk("t5_a_rsp", 32'(bus.a_rsp_valid), 32'd1);
                chk("t5_a_rdata", 32'(bus.a_rdata), 32'hC3);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            set_b(1'b1, 1'b0, 6'(k), 8'h00);
            #1;
            chk($sformatf("t6_rd_ready[%0d]", k), 32'(bus.b_ready), 32'd1);
            chk($sformatf("t6_rsp[%0d]", k), 32'(bus.b_rsp_valid), 32'(k > 0));
            if (k > 0) chk($sformatf("t6_rdata[%0d]", k), 32'(bus.b_rdata), 32'(8'h10 + k - 1));
            @(negedge clk);
        end
        idle_in();
        #1;
        chk("t6_rsp_last", 32'(bus.b_rsp_valid), 32'd1);
        chk("t6_rdata_last", 32'(bus.b_rdata), 32'h15);
        chk("t6_a_rsp", 32'(bus.a_rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("t6_rsp_end", 32'(bus.b_rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
